srec_writer: RTL and testbench

Memory-to-S-record dump engine, the transmit-side counterpart of `srec_parser`. On `start` it reads a word-aligned region of the memory behind `mem_controller` through the same address/wren/data port. It then emits the contents as an ASCII Motorola S-record stream: S3 data records followed by one S7 termination record. Characters leave on a valid/ready byte handshake, for post-simulation memory dumps and result checking in stage benches.

---
 rtl/srec_writer.sv | 146 ++++++++++++++
 tb/tb_srec_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srec_writer.sv
// Memory-to-Motorola-S-record dump engine: reads a word region through the
// mem_controller port and streams S3 data records plus one S7 terminator.
module srec_writer #(
   parameter logic [31:0] BASE_ADDR     = 32'h8002_0000,
   parameter int          WORDS_PER_REC = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [0:31] length,
   output logic [0:31] mem_address,
   output logic        mem_wren,
   input  logic [0:31] mem_data_out,
   output logic [0:7]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, EMIT = 3'd2, TERM = 3'd3, FIN = 3'd4;

   logic [2:0]  state;
   logic [29:0] words_left;
   logic [31:0] offset;
   logic [3:0]  n_rec, ld_cnt;
   logic [6:0]  idx;
   logic [31:0] mem_addr_q;
   logic [31:0] rec_buf [8];

   logic        is_term;
   logic [3:0]  eff_n;
   logic [31:0] rec_addr;
   logic [7:0]  rec_cnt, sum, chk, ch;
   logic [6:0]  last_idx, d;
   logic [2:0]  j;
   logic        unused;

   assign unused = ^length[30:31];

   function automatic logic [3:0] rec_words(input logic [29:0] w);
      return (w < 30'(WORDS_PER_REC)) ? w[3:0] : 4'(WORDS_PER_REC);
   endfunction

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   // Character index walks: S, type, count(2), address(8), data(8N), checksum(2), LF.
   // The S7 terminator reuses the same path with zero data words at BASE_ADDR.
   always_comb begin
      is_term  = (state == TERM);
      eff_n    = is_term ? 4'd0 : n_rec;
      rec_addr = is_term ? BASE_ADDR : BASE_ADDR + offset;
      rec_cnt  = 8'd5 + {2'b00, eff_n, 2'b00};
      sum      = rec_cnt + rec_addr[31:24] + rec_addr[23:16] + rec_addr[15:8] + rec_addr[7:0];
      for (int k = 0; k < 8; k++)
         if (4'(k) < eff_n)
            sum = sum + rec_buf[k][31:24] + rec_buf[k][23:16] + rec_buf[k][15:8] + rec_buf[k][7:0];
      chk      = ~sum;
      last_idx = 7'd14 + {eff_n, 3'b000};
      d        = idx - 7'd12;
      j        = idx[2:0] - 3'd4;
      if (idx == 7'd0)                    ch = 8'h53;
      else if (idx == 7'd1)               ch = is_term ? 8'h37 : 8'h33;
      else if (idx < 7'd4)                ch = hex(idx[0] ? rec_cnt[3:0] : rec_cnt[7:4]);
      else if (idx < 7'd12)               ch = hex(rec_addr[{3'd7 - j, 2'b00} +: 4]);
      else if (idx < last_idx - 7'd2)     ch = hex(rec_buf[d[5:3]][{3'd7 - d[2:0], 2'b00} +: 4]);
      else if (idx == last_idx - 7'd2)    ch = hex(chk[7:4]);
      else if (idx == last_idx - 7'd1)    ch = hex(chk[3:0]);
      else                                ch = 8'h0A;
   end

   assign char_valid  = (state == EMIT) || is_term;
   assign char_out    = char_valid ? ch : 8'h00;
   assign busy        = (state == LOAD) || char_valid;
   assign done        = (state == FIN);
   assign mem_wren    = 1'b0;
   assign mem_address = mem_addr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         mem_addr_q <= '0;
         words_left <= '0;
         offset     <= '0;
         n_rec      <= '0;
         ld_cnt     <= '0;
         idx        <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               words_left <= length[0:29];
               offset     <= '0;
               idx        <= '0;
               ld_cnt     <= '0;
               n_rec      <= rec_words(length[0:29]);
               if (length[0:29] != '0) begin
                  state      <= LOAD;
                  mem_addr_q <= BASE_ADDR;
               end else begin
                  state <= TERM;
               end
            end
            // Address k goes out in cycle k; its data is captured in cycle k+1.
            LOAD: begin
               if (ld_cnt + 4'd1 < n_rec)
                  mem_addr_q <= BASE_ADDR + offset + {26'b0, ld_cnt + 4'd1, 2'b00};
               if (ld_cnt == n_rec) begin
                  state <= EMIT;
                  idx   <= '0;
               end
               ld_cnt <= ld_cnt + 4'd1;
            end
            EMIT, TERM: if (char_ready) begin
               if (idx == last_idx) begin
                  idx <= '0;
                  if (is_term) begin
                     state <= FIN;
                  end else begin
                     offset     <= offset + {26'b0, n_rec, 2'b00};
                     words_left <= words_left - {26'b0, n_rec};
                     if (words_left != {26'b0, n_rec}) begin
                        state      <= LOAD;
                        ld_cnt     <= '0;
                        n_rec      <= rec_words(words_left - {26'b0, n_rec});
                        mem_addr_q <= BASE_ADDR + offset + {26'b0, n_rec, 2'b00};
                     end else begin
                        state <= TERM;
                     end
                  end
               end else begin
                  idx <= idx + 7'd1;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock)
      if (state == LOAD && ld_cnt != 4'd0)
         rec_buf[ld_cnt[2:0] - 3'd1] <= mem_data_out;

endmodule

// File: tb/tb_srec_writer.sv
// Scoreboard bench for srec_writer: a reference model builds the expected
// character stream from memory contents; a monitor checks every transfer.
module tb_srec_writer;
   localparam logic [31:0] BASE = 32'h8002_0000;
   localparam int WPR = 4;

   logic clock = 1'b0;
   logic reset, start, mem_wren, char_valid, char_ready, busy, done;
   logic [0:31] length, mem_address, mem_data_out;
   logic [0:7]  char_out;

   srec_writer #(.BASE_ADDR(BASE), .WORDS_PER_REC(WPR)) dut (
      .clock(clock), .reset(reset), .start(start), .length(length),
      .mem_address(mem_address), .mem_wren(mem_wren), .mem_data_out(mem_data_out),
      .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
      .busy(busy), .done(done));

   always #5 clock = ~clock;

   logic [31:0] mem [64];
   always @(posedge clock) mem_data_out <= mem[6'((mem_address - BASE) >> 2)];

   logic [7:0] exp_q[$];
   int n_cmp = 0, n_bad = 0, done_cnt = 0, xfer_cnt = 0;
   bit stall_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] hexc(input int n);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
   endfunction

   task automatic push_hex(input logic [7:0] b);
      exp_q.push_back(hexc(int'(b[7:4])));
      exp_q.push_back(hexc(int'(b[3:0])));
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic push_rec(input logic [7:0] typ, input logic [31:0] addr, input int n, input int first);
      int s;
      logic [31:0] w;
      exp_q.push_back(8'h53);
      exp_q.push_back(typ);
      s = 4 * n + 5;
      push_hex(8'(s));
      for (int b = 3; b >= 0; b--) begin
         push_hex(8'(addr >> (8 * b)));
         s += int'(8'(addr >> (8 * b)));
      end
      for (int k = 0; k < n; k++) begin
         w = mem[first + k];
         for (int b = 3; b >= 0; b--) begin
            push_hex(8'(w >> (8 * b)));
            s += int'(8'(w >> (8 * b)));
         end
      end
      push_hex(~8'(s));
      exp_q.push_back(8'h0A);
   endtask

   task automatic push_model(input int len);
      int w, off, n;
      w = len / 4;
      off = 0;
      while (w > 0) begin
         n = (w < WPR) ? w : WPR;
         push_rec("3", BASE + off, n, off / 4);
         off += 4 * n;
         w -= n;
      end
      push_rec("7", BASE, 0, 0);
   endtask

   function automatic int exp_cyc(input int len);
      int w, n, t;
      w = len / 4;
      t = 0;
      while (w > 0) begin
         n = (w < WPR) ? w : WPR;
         t += (n + 1) + (15 + 8 * n);
         w -= n;
      end
      return t + 15 + 1;
   endfunction

   // ---------------- sink handshake ----------------
   initial begin
      int stall_left;
      stall_left = 0;
      char_ready = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (!stall_mode) char_ready = 1'b1;
         else if (stall_left > 0) begin
            char_ready = 1'b0;
            stall_left--;
         end else begin
            char_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 5);
         end
      end
   end

   // ---------------- monitor ----------------
   logic pv = 0, pr = 0, prst = 1;
   logic [7:0] pc = 0;
   always @(negedge clock) begin
      if (!reset) begin
         if (pv && !pr && !prst) begin
            check("hold_valid", 32'(char_valid), 32'd1);
            check("hold_char", 32'(char_out), 32'(pc));
         end
         if (char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_char: got %0h expected none", char_out);
            end else begin
               check("char", 32'(char_out), 32'(exp_q.pop_front()));
            end
            xfer_cnt++;
         end
         if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
      pv = char_valid; pr = char_ready; prst = reset; pc = char_out;
   end

   // ---------------- driver ----------------
   task automatic issue_start(input int len);
      @(posedge clock); #1;
      start = 1'b1;
      length = 32'(len);
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic do_dump(input int len, input int cyc_exp, input bit restart);
      int cyc, d0;
      d0 = done_cnt;
      issue_start(len);
      @(negedge clock);
      cyc = 1;
      check("busy_after_start", 32'(busy), 32'd1);
      if (len >= 4) check("first_addr", mem_address, BASE);
      while (done !== 1'b1 && cyc < 6000) begin
         @(negedge clock);
         cyc++;
         if (restart && cyc == 5) begin start = 1'b1; length = 32'd8; end
         if (restart && cyc == 6) start = 1'b0;
      end
      if (cyc >= 6000) check("done_timeout", 32'(cyc), 32'd0);
      else if (cyc_exp > 0) check("dump_cycles", 32'(cyc), 32'(cyc_exp));
      repeat (3) @(negedge clock);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int len, x0, t;
      reset = 1'b1; start = 1'b0; length = '0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_wren", 32'(mem_wren), 32'd0);
      check("rst_char_out", 32'(char_out), 32'd0);
      check("rst_char_valid", 32'(char_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clock); #1 reset = 1'b0;

      // zero length: terminator only, memory port untouched
      push_str("S7058002000078\n");
      do_dump(0, exp_cyc(0), 0);
      check("len0_addr_untouched", mem_address, 32'd0);

      // single known word
      mem[0] = 32'h1234_5678;
      push_str("S309800200001234567860\n");
      push_str("S7058002000078\n");
      do_dump(4, exp_cyc(4), 0);

      // 22 bytes -> 5 words over two records
      push_model(22);
      do_dump(22, exp_cyc(22), 0);

      // random lengths with sink stalls
      stall_mode = 1;
      for (int i = 0; i < 4; i++) begin
         len = $urandom_range(0, 120);
         push_model(len);
         do_dump(len, 0, 0);
      end
      stall_mode = 0;

      // random lengths, back-to-back sink, cycle-exact
      for (int i = 0; i < 3; i++) begin
         len = $urandom_range(1, 120);
         push_model(len);
         do_dump(len, exp_cyc(len), 0);
      end

      // second start while busy must be ignored
      push_model(40);
      do_dump(40, exp_cyc(40), 1);

      // reset in the middle of the first record's data digits
      push_model(32);
      x0 = xfer_cnt;
      issue_start(32);
      t = 0;
      while (xfer_cnt - x0 < 16 && t < 500) begin
         @(negedge clock);
         t++;
      end
      if (t >= 500) check("midreset_wait", 32'(t), 32'd0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check("midreset_valid", 32'(char_valid), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      exp_q.delete();
      push_model(32);
      do_dump(32, exp_cyc(32), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
